// File: rtl/sd_spi_master_pkg.sv
// Shared definitions for the SD-card SPI master: FSM encodings and control-register bit positions.
// The control bit positions are also used by the IO register decode.
package sd_spi_master_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLow  = 2'd1,
    StHigh = 2'd2
  } spi_state_e;

  localparam int unsigned CTRL_CS    = 0;
  localparam int unsigned CTRL_SPEED = 1;

endpackage

// File: rtl/sd_spi_clkdiv.sv
// SCLK half-period down-counter. It reloads with HALF-1 on load or when it expires, and it
// emits a one-cycle tick when it reaches zero while enabled.
module sd_spi_clkdiv #(
  parameter int unsigned SLOW_HALF = 20,
  parameter int unsigned FAST_HALF = 1,
  parameter int unsigned CNT_W     = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  input  logic speed,
  output logic tick
);

  localparam logic [CNT_W-1:0] SlowReload = CNT_W'(SLOW_HALF - 1);
  localparam logic [CNT_W-1:0] FastReload = CNT_W'(FAST_HALF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] reload;

  assign reload = speed ? FastReload : SlowReload;
  assign tick   = en && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load || tick) begin
      cnt_d = reload;
    end else if (en) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sd_spi_master.sv
// Byte-wide mode-0 SPI master for the SD card. Holds the control register, transfer FSM,
// shift register, bit counter and received-byte register; all outputs are registered.
module sd_spi_master
  import sd_spi_master_pkg::*;
#(
  parameter int unsigned SLOW_HALF = 20,
  parameter int unsigned FAST_HALF = 1,
  parameter int unsigned CNT_W     = 5
) (
  input  logic       CLKX4,
  input  logic       RESET,
  input  logic       WR_DATA,
  input  logic       WR_CTRL,
  input  logic [7:0] DIN,
  output logic [7:0] RXDATA,
  output logic       BUSY,
  output logic       ERR,
  output logic       SPEED,
  output logic       SD_nCS,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO
);

  spi_state_e state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] rxdata_q, rxdata_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       busy_q, busy_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       speed_q, speed_d;
  logic       cs_n_q, cs_n_d;
  logic       err_q, err_d;
  logic       load;
  logic       tick;

  // Control register; a data write while busy sets ERR even if a control write clears it.
  always_comb begin
    speed_d = speed_q;
    cs_n_d  = cs_n_q;
    err_d   = err_q;
    if (WR_CTRL) begin
      speed_d = DIN[CTRL_SPEED];
      cs_n_d  = ~DIN[CTRL_CS];
      err_d   = 1'b0;
    end
    if (WR_DATA && busy_q) begin
      err_d = 1'b1;
    end
  end

  // The divider sees the incoming SPEED so a combined control+data write uses the new rate.
  sd_spi_clkdiv #(
    .SLOW_HALF(SLOW_HALF),
    .FAST_HALF(FAST_HALF),
    .CNT_W    (CNT_W)
  ) u_clkdiv (
    .clk  (CLKX4),
    .rst  (RESET),
    .en   (state_q != StIdle),
    .load (load),
    .speed(speed_d),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    rxdata_d = rxdata_q;
    bitcnt_d = bitcnt_q;
    busy_d   = busy_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    load     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (WR_DATA) begin
          state_d  = StLow;
          busy_d   = 1'b1;
          sclk_d   = 1'b0;
          mosi_d   = DIN[7];
          shreg_d  = DIN;
          bitcnt_d = 3'd0;
          load     = 1'b1;
        end
      end
      StLow: begin
        if (tick) begin
          state_d = StHigh;
          sclk_d  = 1'b1;
          shreg_d = {shreg_q[6:0], MISO};
        end
      end
      StHigh: begin
        if (tick) begin
          sclk_d = 1'b0;
          if (bitcnt_q == 3'd7) begin
            state_d  = StIdle;
            mosi_d   = 1'b1;
            busy_d   = 1'b0;
            rxdata_d = shreg_q;
          end else begin
            state_d  = StLow;
            mosi_d   = shreg_q[7];
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLKX4 or posedge RESET) begin
    if (RESET) begin
      state_q  <= StIdle;
      shreg_q  <= 8'h00;
      rxdata_q <= 8'hFF;
      bitcnt_q <= 3'd0;
      busy_q   <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b1;
      speed_q  <= 1'b0;
      cs_n_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      rxdata_q <= rxdata_d;
      bitcnt_q <= bitcnt_d;
      busy_q   <= busy_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      speed_q  <= speed_d;
      cs_n_q   <= cs_n_d;
      err_q    <= err_d;
    end
  end

  assign RXDATA = rxdata_q;
  assign BUSY   = busy_q;
  assign ERR    = err_q;
  assign SPEED  = speed_q;
  assign SD_nCS = cs_n_q;
  assign SCLK   = sclk_q;
  assign MOSI   = mosi_q;

endmodule

// File: tb/tb_sd_spi_master.sv
// Directed bench for sd_spi_master: expected received bytes are queued at each transfer start
// and compared when BUSY falls; timing, MOSI pattern and control/error flags are checked inline.
module tb_sd_spi_master;

  localparam int unsigned SlowHalf = 20;
  localparam int unsigned FastHalf = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_data;
  logic       wr_ctrl;
  logic [7:0] din;
  logic [7:0] rxdata;
  logic       busy;
  logic       err;
  logic       speed;
  logic       sd_ncs;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       loop_en;
  logic       miso_fix;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  assign miso = loop_en ? mosi : miso_fix;

  always #5 clk = ~clk;

  sd_spi_master #(
    .SLOW_HALF(SlowHalf),
    .FAST_HALF(FastHalf),
    .CNT_W    (5)
  ) dut (
    .CLKX4  (clk),
    .RESET  (rst),
    .WR_DATA(wr_data),
    .WR_CTRL(wr_ctrl),
    .DIN    (din),
    .RXDATA (rxdata),
    .BUSY   (busy),
    .ERR    (err),
    .SPEED  (speed),
    .SD_nCS (sd_ncs),
    .SCLK   (sclk),
    .MOSI   (mosi),
    .MISO   (miso)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl_write(input logic [7:0] d);
    din     = d;
    wr_ctrl = 1'b1;
    step();
    wr_ctrl = 1'b0;
  endtask

  // Starts a transfer and follows it until BUSY drops. If err_at >= 0, a second WR_DATA
  // carrying err_din is pulsed at that busy-cycle index.
  task automatic run_xfer(input string tag, input logic [7:0] d, input logic [7:0] exp_rx,
                          input int half, input bit with_ctrl, input int err_at,
                          input logic [7:0] err_din);
    int i = 0;
    int rises = 0;
    int first = -1;
    int bound = 16 * half + 50;
    logic prev = 1'b0;
    logic [7:0] bits = 8'h00;
    logic [7:0] got;
    din     = d;
    wr_data = 1'b1;
    wr_ctrl = with_ctrl;
    exp_q.push_back(exp_rx);
    step();
    wr_data = 1'b0;
    wr_ctrl = 1'b0;
    while (busy && i < bound) begin
      if (sclk && !prev) begin
        rises++;
        bits = {bits[6:0], mosi};
        if (first < 0) first = i;
      end
      prev = sclk;
      if (i == err_at) begin
        din     = err_din;
        wr_data = 1'b1;
      end else begin
        wr_data = 1'b0;
      end
      step();
      i++;
    end
    wr_data = 1'b0;
    check({tag, "_busy_cycles"}, i, 16 * half);
    check({tag, "_sclk_rises"}, rises, 8);
    check({tag, "_first_rise"}, first, half);
    check({tag, "_mosi_bits"}, {24'h0, bits}, {24'h0, d});
    got = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
    check({tag, "_rxdata"}, {24'h0, rxdata}, {24'h0, got});
  endtask

  initial begin
    int rises;
    int i;
    logic prev;
    rst      = 1'b1;
    wr_data  = 1'b0;
    wr_ctrl  = 1'b0;
    din      = 8'h00;
    loop_en  = 1'b1;
    miso_fix = 1'b0;
    step();
    step();
    check("rst_rxdata", {24'h0, rxdata}, 32'hFF);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_speed", speed, 0);
    check("rst_ncs", sd_ncs, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 1);
    rst = 1'b0;
    step();

    // Loopback at fast rate
    ctrl_write(8'h03);
    check("ctrl_speed", speed, 1);
    check("ctrl_ncs", sd_ncs, 0);
    run_xfer("loop_a5", 8'hA5, 8'hA5, FastHalf, 1'b0, -1, 8'h00);
    check("idle_sclk", sclk, 0);
    check("idle_mosi", mosi, 1);

    // Slow rate, MISO held low
    ctrl_write(8'h01);
    loop_en = 1'b0;
    run_xfer("slow_3c", 8'h3C, 8'h00, SlowHalf, 1'b0, -1, 8'h00);

    // Write during transfer is rejected
    loop_en = 1'b1;
    run_xfer("err_55", 8'h55, 8'h55, SlowHalf, 1'b0, 5, 8'hFF);
    check("err_set", err, 1);
    ctrl_write(8'h03);
    check("err_clr", err, 0);
    check("err_speed", speed, 1);
    check("err_ncs", sd_ncs, 0);

    // Write on the exact cycle BUSY falls is rejected; one cycle later is accepted
    run_xfer("b2b_0f", 8'h0F, 8'h0F, FastHalf, 1'b0, 16 * FastHalf - 1, 8'hC0);
    check("b2b_err", err, 1);
    step();
    check("b2b_no_start", busy, 0);
    run_xfer("b2b_next_96", 8'h96, 8'h96, FastHalf, 1'b0, -1, 8'h00);

    // Combined control and data write in IDLE uses the new speed
    ctrl_write(8'h01);
    check("comb_pre_speed", speed, 0);
    run_xfer("comb_02", 8'h02, 8'h02, FastHalf, 1'b1, -1, 8'h00);
    check("comb_ncs", sd_ncs, 1);
    check("comb_err", err, 0);

    // Reset mid-transfer
    ctrl_write(8'h01);
    din     = 8'hC3;
    wr_data = 1'b1;
    step();
    wr_data = 1'b0;
    rises = 0;
    prev  = 1'b0;
    i     = 0;
    while (rises < 3 && i < 200) begin
      if (sclk && !prev) rises++;
      prev = sclk;
      step();
      i++;
    end
    check("mid_rises", rises, 3);
    rst = 1'b1;
    #1;
    check("mid_sclk", sclk, 0);
    check("mid_mosi", mosi, 1);
    check("mid_busy", busy, 0);
    check("mid_ncs", sd_ncs, 1);
    check("mid_rxdata", {24'h0, rxdata}, 32'hFF);
    step();
    rst   = 1'b0;
    rises = 0;
    prev  = sclk;
    for (int k = 0; k < 100; k++) begin
      if (sclk && !prev) rises++;
      prev = sclk;
      step();
    end
    check("post_rst_rises", rises, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_rxdata", {24'h0, rxdata}, 32'hFF);
    check("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
